// File: rtl/ipm2t_hssthp_rx_link_sync_32b_pkg.sv
// Shared definitions for the HSST HP receive link-synchronisation stage:
// LSM state encodings, the K28.5 comma constant and the error counter width.
package ipm2t_hssthp_rx_link_sync_32b_pkg;

    typedef enum logic [1:0] {
        LSM_LOS      = 2'd0,
        LSM_CHECK    = 2'd1,
        LSM_SYNC     = 2'd2,
        LSM_SYNC_ERR = 2'd3
    } lsm_state_t;

    localparam logic [7:0] K28_5     = 8'hBC;
    localparam int         ERR_CNT_W = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    // Data is only qualified while the link is considered synchronised.
    function automatic logic lsm_is_synced(input lsm_state_t s);
        return (s == LSM_SYNC) || (s == LSM_SYNC_ERR);
    endfunction

endpackage

// File: rtl/ipm2t_hssthp_rx_link_sync_32b_if.sv
// Aligned-word bus from the comma aligner and the registered word handed downstream.
interface ipm2t_hssthp_rx_link_sync_32b_if;

    logic        i_comma_aligned;
    logic [31:0] i_align_rxd;
    logic [3:0]  i_align_rxk;
    logic [3:0]  i_align_rdisper;
    logic [3:0]  i_align_rdecer;
    logic [31:0] o_rxd;
    logic [3:0]  o_rxk;
    logic        o_rx_valid;

    // master: aligner side / consumer of the qualified word
    modport master (
        output i_comma_aligned, i_align_rxd, i_align_rxk, i_align_rdisper, i_align_rdecer,
        input  o_rxd, o_rxk, o_rx_valid
    );

    // slave: the link-synchronisation stage
    modport slave (
        input  i_comma_aligned, i_align_rxd, i_align_rxk, i_align_rdisper, i_align_rdecer,
        output o_rxd, o_rxk, o_rx_valid
    );

endinterface

// File: rtl/ipm2t_hssthp_rx_word_check.sv
// Combinational per-word decode of one 4-byte slice: error, leading comma and
// comma found in a non-zero byte lane. Reusable for the high lane in 64-bit mode.
module ipm2t_hssthp_rx_word_check
    import ipm2t_hssthp_rx_link_sync_32b_pkg::*;
#(
    parameter logic [7:0] COMMA = K28_5
) (
    input  logic [31:0] rxd,
    input  logic [3:0]  rxk,
    input  logic [3:0]  rdisper,
    input  logic [3:0]  rdecer,
    output logic        bad,
    output logic        comma0,
    output logic        misplaced
);

    logic [3:0] comma_byte;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign comma_byte[gi] = rxk[gi] & (rxd[8*gi +: 8] == COMMA);
        end
    endgenerate

    assign bad       = |(rdisper | rdecer);
    assign comma0    = comma_byte[0] & ~bad;
    assign misplaced = |comma_byte[3:1];

endmodule

// File: rtl/ipm2t_hssthp_rx_link_sync_32b.sv
// Receive link-synchronisation stage: loss-of-sync state machine, error budget,
// saturating bad-word counter and one-cycle registered data path.
module ipm2t_hssthp_rx_link_sync_32b
    import ipm2t_hssthp_rx_link_sync_32b_pkg::*;
#(
    parameter logic [7:0] COMMA        = K28_5,
    parameter int         SYNC_CNT     = 4,
    parameter int         ERR_LIMIT    = 4,
    parameter int         GOOD_RECOVER = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 i_err_cnt_clr,
    ipm2t_hssthp_rx_link_sync_32b_if.slave rx,
    output logic                 o_link_sync,
    output logic [1:0]           o_lsm_state,
    output logic                 o_realign_req,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam logic [3:0] SYNC_CNT_C     = 4'(SYNC_CNT);
    localparam logic [3:0] ERR_LIMIT_C    = 4'(ERR_LIMIT);
    localparam logic [7:0] GOOD_RECOVER_C = 8'(GOOD_RECOVER);

    logic bad, comma0, misplaced, fault;

    lsm_state_t           state_reg, state_next;
    logic [3:0]           cnt_reg, cnt_next;
    logic [3:0]           budget_reg, budget_next;
    logic [7:0]           good_reg, good_next;
    logic                 realign_reg, realign_next;
    logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;
    logic                 link_sync_reg;
    logic [31:0]          rxd_reg;
    logic [3:0]           rxk_reg;
    logic                 rx_valid_reg;

    ipm2t_hssthp_rx_word_check #(
        .COMMA (COMMA)
    ) u_word_check (
        .rxd       (rx.i_align_rxd),
        .rxk       (rx.i_align_rxk),
        .rdisper   (rx.i_align_rdisper),
        .rdecer    (rx.i_align_rdecer),
        .bad       (bad),
        .comma0    (comma0),
        .misplaced (misplaced)
    );

    assign fault = bad | misplaced;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        budget_next  = budget_reg;
        good_next    = good_reg;
        realign_next = 1'b0;
        if (!enable) begin
            state_next  = LSM_LOS;
            cnt_next    = '0;
            budget_next = '0;
            good_next   = '0;
        end else begin
            case (state_reg)
                LSM_LOS: begin
                    if (rx.i_comma_aligned && comma0) begin
                        if (SYNC_CNT == 1) begin
                            state_next = LSM_SYNC;
                            cnt_next   = '0;
                        end else begin
                            state_next = LSM_CHECK;
                            cnt_next   = 4'd1;
                        end
                    end
                end
                LSM_CHECK: begin
                    if (fault || !rx.i_comma_aligned) begin
                        state_next = LSM_LOS;
                        cnt_next   = '0;
                    end else if (comma0) begin
                        if (cnt_reg + 4'd1 == SYNC_CNT_C) begin
                            state_next = LSM_SYNC;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + 4'd1;
                        end
                    end
                end
                LSM_SYNC: begin
                    if (fault) begin
                        state_next  = LSM_SYNC_ERR;
                        budget_next = 4'd1;
                        good_next   = '0;
                    end
                end
                LSM_SYNC_ERR: begin
                    if (fault) begin
                        good_next = '0;
                        // Error budget exhausted: drop sync and ask the aligner to re-hunt.
                        if (budget_reg + 4'd1 == ERR_LIMIT_C) begin
                            state_next   = LSM_LOS;
                            budget_next  = '0;
                            realign_next = 1'b1;
                        end else begin
                            budget_next = budget_reg + 4'd1;
                        end
                    end else if (good_reg + 8'd1 == GOOD_RECOVER_C) begin
                        good_next   = '0;
                        budget_next = budget_reg - 4'd1;
                        if (budget_reg == 4'd1) begin
                            state_next = LSM_SYNC;
                        end
                    end else begin
                        good_next = good_reg + 8'd1;
                    end
                end
                default: begin
                    state_next = LSM_LOS;
                end
            endcase
        end
    end

    // Counting follows the current state, independent of enable.
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (i_err_cnt_clr) begin
            err_cnt_next = '0;
        end else if (bad && lsm_is_synced(state_reg) && (err_cnt_reg != ERR_CNT_MAX)) begin
            err_cnt_next = err_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= LSM_LOS;
            cnt_reg       <= '0;
            budget_reg    <= '0;
            good_reg      <= '0;
            realign_reg   <= 1'b0;
            err_cnt_reg   <= '0;
            link_sync_reg <= 1'b0;
            rxd_reg       <= '0;
            rxk_reg       <= '0;
            rx_valid_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            budget_reg    <= budget_next;
            good_reg      <= good_next;
            realign_reg   <= realign_next;
            err_cnt_reg   <= err_cnt_next;
            link_sync_reg <= lsm_is_synced(state_next);
            rxd_reg       <= rx.i_align_rxd;
            rxk_reg       <= rx.i_align_rxk;
            rx_valid_reg  <= lsm_is_synced(state_next) & ~bad;
        end
    end

    assign rx.o_rxd      = rxd_reg;
    assign rx.o_rxk      = rxk_reg;
    assign rx.o_rx_valid = rx_valid_reg;
    assign o_link_sync   = link_sync_reg;
    assign o_lsm_state   = state_reg;
    assign o_realign_req = realign_reg;
    assign o_err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_ipm2t_hssthp_rx_link_sync_32b.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// a randomized run scored against a behavioural model of the link state rules.
module tb_ipm2t_hssthp_rx_link_sync_32b;

    localparam logic [31:0] WC = 32'h4A4A4ABC;
    localparam logic [31:0] WD = 32'h12345678;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        clr;
    logic        o_link_sync;
    logic [1:0]  o_lsm_state;
    logic        o_realign_req;
    logic [15:0] o_err_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    ipm2t_hssthp_rx_link_sync_32b_if rx_if ();

    ipm2t_hssthp_rx_link_sync_32b dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .i_err_cnt_clr (clr),
        .rx            (rx_if),
        .o_link_sync   (o_link_sync),
        .o_lsm_state   (o_lsm_state),
        .o_realign_req (o_realign_req),
        .o_err_cnt     (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        ca;
        logic [31:0] d;
        logic [3:0]  k;
        logic [3:0]  dp;
        logic [3:0]  de;
        logic        clr;
        logic [1:0]  st;
        logic        vld;
        logic        rr;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [31:0] d, input logic [3:0] k, input logic [3:0] dp,
                               input logic [3:0] de, input logic [1:0] st, input logic vld,
                               input logic rr, input logic [15:0] ec);
        vec_t r;
        r.en = 1'b1; r.ca = 1'b1; r.d = d; r.k = k; r.dp = dp; r.de = de; r.clr = 1'b0;
        r.st = st; r.vld = vld; r.rr = rr; r.ec = ec;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic ca, input logic [31:0] d, input logic [3:0] k,
                         input logic [3:0] dp, input logic [3:0] de, input logic c);
        enable                = en;
        rx_if.i_comma_aligned = ca;
        rx_if.i_align_rxd     = d;
        rx_if.i_align_rxk     = k;
        rx_if.i_align_rdisper = dp;
        rx_if.i_align_rdecer  = de;
        clr                   = c;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic acquire;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, WC, 4'b0001, 0, 0, 0);
            tick();
        end
        chk("acquire_state", 32'(o_lsm_state), 32'd2);
    endtask

    // Behavioural model: states numbered as on o_lsm_state, rules taken word by word.
    int m_st, m_cnt, m_bud, m_good, m_ec;

    task automatic model_reset;
        m_st = 0; m_cnt = 0; m_bud = 0; m_good = 0; m_ec = 0;
    endtask

    task automatic model_step(input logic en, input logic ca, input logic [31:0] d,
                              input logic [3:0] k, input logic [3:0] dp, input logic [3:0] de,
                              input logic c, output int nst, output bit vld, output bit rr);
        bit bad, c0, mis, flt;
        logic [7:0] byte_v;
        bad = ((dp | de) != 4'd0);
        c0  = k[0] && (d[7:0] == 8'hBC) && !bad;
        mis = 0;
        for (int b = 1; b < 4; b++) begin
            byte_v = d[8*b +: 8];
            if (k[b] && byte_v == 8'hBC) mis = 1;
        end
        flt = bad || mis;
        rr  = 0;
        nst = m_st;
        if (c) m_ec = 0;
        else if (bad && m_st >= 2 && m_ec < 65535) m_ec = m_ec + 1;
        if (!en) begin
            nst = 0; m_cnt = 0; m_bud = 0; m_good = 0;
        end else if (m_st == 0) begin
            if (ca && c0) begin nst = 1; m_cnt = 1; end
        end else if (m_st == 1) begin
            if (flt || !ca) begin nst = 0; m_cnt = 0; end
            else if (c0) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == 4) begin nst = 2; m_cnt = 0; end
            end
        end else if (m_st == 2) begin
            if (flt) begin nst = 3; m_bud = 1; m_good = 0; end
        end else begin
            if (flt) begin
                m_bud = m_bud + 1; m_good = 0;
                if (m_bud == 4) begin nst = 0; m_bud = 0; rr = 1; end
            end else begin
                m_good = m_good + 1;
                if (m_good == 16) begin
                    m_good = 0; m_bud = m_bud - 1;
                    if (m_bud == 0) nst = 2;
                end
            end
        end
        m_st = nst;
        vld  = (nst >= 2) && !bad;
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0]  rk, rdp, rde;
        logic        ren, rca, rclr;
        int          sel, nst;
        bit          evld, err;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_state", 32'(o_lsm_state), 0);
        chk("rst_sync", 32'(o_link_sync), 0);
        chk("rst_valid", 32'(rx_if.o_rx_valid), 0);
        chk("rst_realign", 32'(o_realign_req), 0);
        chk("rst_errcnt", 32'(o_err_cnt), 0);
        chk("rst_rxd", rx_if.o_rxd, 0);
        rst = 1'b0;

        // check abort, acquisition, loss through errors
        tbl.push_back(v(WC, 4'b0001, 0, 0, 2'd1, 0, 0, 0));
        tbl.push_back(v(WC, 4'b0001, 0, 0, 2'd1, 0, 0, 0));
        tbl.push_back(v(WD, 4'b0000, 0, 4'b0100, 2'd0, 0, 0, 0));
        tbl.push_back(v(WC, 4'b0001, 0, 0, 2'd1, 0, 0, 0));
        tbl.push_back(v(WC, 4'b0001, 0, 0, 2'd1, 0, 0, 0));
        tbl.push_back(v(WC, 4'b0001, 0, 0, 2'd1, 0, 0, 0));
        tbl.push_back(v(WC, 4'b0001, 0, 0, 2'd2, 1, 0, 0));
        tbl.push_back(v(WD, 4'b0000, 0, 0, 2'd2, 1, 0, 0));
        tbl.push_back(v(WD, 4'b0000, 4'b0001, 0, 2'd3, 0, 0, 1));
        tbl.push_back(v(WD, 4'b0000, 4'b0001, 0, 2'd3, 0, 0, 2));
        tbl.push_back(v(WD, 4'b0000, 4'b0001, 0, 2'd3, 0, 0, 3));
        tbl.push_back(v(WD, 4'b0000, 4'b0001, 0, 2'd0, 0, 1, 4));
        tbl.push_back(v(WD, 4'b0000, 0, 0, 2'd0, 0, 0, 4));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].ca, tbl[i].d, tbl[i].k, tbl[i].dp, tbl[i].de, tbl[i].clr);
            tick();
            $display("row %0d: d=%h k=%b st=%0d sync=%0d vld=%0d rr=%0d ec=%0d", i, tbl[i].d,
                     tbl[i].k, o_lsm_state, o_link_sync, rx_if.o_rx_valid, o_realign_req, o_err_cnt);
            chk("tbl_state", 32'(o_lsm_state), 32'(tbl[i].st));
            chk("tbl_sync", 32'(o_link_sync), 32'(tbl[i].st[1]));
            chk("tbl_valid", 32'(rx_if.o_rx_valid), 32'(tbl[i].vld));
            chk("tbl_realign", 32'(o_realign_req), 32'(tbl[i].rr));
            chk("tbl_errcnt", 32'(o_err_cnt), 32'(tbl[i].ec));
            chk("tbl_rxd", rx_if.o_rxd, tbl[i].d);
            chk("tbl_rxk", 32'(rx_if.o_rxk), 32'(tbl[i].k));
        end

        // clear in LOS, then recovery: one bad word retired by 16 clean words
        drive(1, 1, WD, 0, 0, 0, 1);
        tick();
        chk("clr_los", 32'(o_err_cnt), 0);
        acquire();
        drive(1, 1, WD, 0, 4'b0010, 0, 0);
        tick();
        $display("recover: bad word st=%0d ec=%0d", o_lsm_state, o_err_cnt);
        chk("recover_bad_state", 32'(o_lsm_state), 3);
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, WD, 0, 0, 0, 0);
            tick();
            $display("recover: clean %0d st=%0d", i, o_lsm_state);
            chk("recover_state", 32'(o_lsm_state), (i < 15) ? 32'd3 : 32'd2);
            chk("recover_sync", 32'(o_link_sync), 1);
        end
        chk("recover_errcnt", 32'(o_err_cnt), 1);

        // misplaced comma: fault without counting an error
        drive(1, 1, 32'h00BC0000, 4'b0100, 0, 0, 0);
        tick();
        $display("misplaced: st=%0d ec=%0d vld=%0d", o_lsm_state, o_err_cnt, rx_if.o_rx_valid);
        chk("misplaced_state", 32'(o_lsm_state), 3);
        chk("misplaced_errcnt", 32'(o_err_cnt), 1);
        chk("misplaced_valid", 32'(rx_if.o_rx_valid), 1);
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, WD, 0, 0, 0, 0);
            tick();
        end
        chk("misplaced_recover", 32'(o_lsm_state), 2);

        // enable low mid-SYNC
        drive(0, 1, WD, 0, 0, 0, 0);
        tick();
        $display("disable: st=%0d rr=%0d", o_lsm_state, o_realign_req);
        chk("disable_state", 32'(o_lsm_state), 0);
        chk("disable_realign", 32'(o_realign_req), 0);
        chk("disable_sync", 32'(o_link_sync), 0);
        chk("disable_errcnt", 32'(o_err_cnt), 1);

        // saturation: preload the counter near the top, then keep errors coming
        acquire();
        force dut.err_cnt_reg = 16'hFFFD;
        release dut.err_cnt_reg;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, WD, 0, 0, 4'b1000, 0);
            tick();
            $display("saturate %0d: st=%0d ec=%h", i, o_lsm_state, o_err_cnt);
            chk("sat_errcnt", 32'(o_err_cnt), (i == 0) ? 32'hFFFE : 32'hFFFF);
        end
        chk("sat_state", 32'(o_lsm_state), 0);
        acquire();
        drive(1, 1, WD, 0, 4'b0001, 0, 1);
        tick();
        $display("clr+bad: st=%0d ec=%0d", o_lsm_state, o_err_cnt);
        chk("clr_wins", 32'(o_err_cnt), 0);
        chk("clr_state", 32'(o_lsm_state), 3);

        // reset mid-operation
        rst = 1'b1;
        drive(1, 1, WC, 4'b0001, 0, 0, 0);
        tick();
        rst = 1'b0;
        $display("midrst: st=%0d sync=%0d rxd=%h", o_lsm_state, o_link_sync, rx_if.o_rxd);
        chk("midrst_state", 32'(o_lsm_state), 0);
        chk("midrst_sync", 32'(o_link_sync), 0);
        chk("midrst_rxd", rx_if.o_rxd, 0);
        chk("midrst_valid", 32'(rx_if.o_rx_valid), 0);

        // randomized run against the model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int t = 0; t < 2000; t++) begin
            ren  = ($urandom_range(0, 99) != 0);
            rca  = ($urandom_range(0, 49) != 0);
            rclr = ($urandom_range(0, 199) == 0);
            rd   = $urandom;
            rk   = 4'b0000;
            rdp  = 4'b0000;
            rde  = 4'b0000;
            sel  = $urandom_range(0, 99);
            if (sel < 45) begin
                rd[7:0] = 8'hBC;
                rk = 4'b0001;
            end else if (sel < 85) begin
                rk = 4'b0000;
            end else if (sel < 94) begin
                rk = 4'($urandom_range(0, 15));
                err = ($urandom_range(0, 1) != 0);
                if (err) rdp = 4'(1 << $urandom_range(0, 3));
                else     rde = 4'(1 << $urandom_range(0, 3));
            end else begin
                rd[23:16] = 8'hBC;
                rd[7:0]   = 8'hBC;
                rk = 4'b0101;
            end
            model_step(ren, rca, rd, rk, rdp, rde, rclr, nst, evld, err);
            drive(ren, rca, rd, rk, rdp, rde, rclr);
            tick();
            $display("rnd %0d: en=%0d ca=%0d d=%h k=%b st=%0d ec=%0d", t, ren, rca, rd, rk,
                     o_lsm_state, o_err_cnt);
            chk("rnd_state", 32'(o_lsm_state), 32'(nst));
            chk("rnd_sync", 32'(o_link_sync), (nst >= 2) ? 32'd1 : 32'd0);
            chk("rnd_valid", 32'(rx_if.o_rx_valid), 32'(evld));
            chk("rnd_realign", 32'(o_realign_req), 32'(err));
            chk("rnd_errcnt", 32'(o_err_cnt), 32'(m_ec));
            chk("rnd_rxd", rx_if.o_rxd, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
